xdma_axi_write_fsm: RTL and testbench
=====================================

Name: xdma_axi_write_fsm

Overview:
- Upstream write engine of the XDMA AXI adapter.
- Accepts one write transfer request (base address, length in beats) and splits it into AXI4 INCR bursts of at most MaxBurstBeats.
- For each burst: issues AW, streams W beats from a valid/ready data source with correct WLAST, then waits for B.
- Drives busy_o/trans_len_o to the downstream xdma_req_counter, which observes the same W handshakes.

Parameters:
AddrWidth, 48, AXI address width
DataWidth, 512, W data width in bits; power of two, >= 8
LenWidth, 16, width of transfer length in beats
MaxBurstBeats, 256, maximum beats per AXI burst; 1..256

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_ni  input  1  asynchronous active-low reset
req_valid_i  input  1  transfer request valid
req_ready_o  output  1  request accepted when high with req_valid_i
req_addr_i  input  AddrWidth  start byte address, aligned to DataWidth/8
req_len_i  input  LenWidth  total beats; 0 = empty transfer
data_valid_i  input  1  write data stream valid
data_ready_o  output  1  write data stream ready
data_i  input  DataWidth  write data
aw_valid_o  output  1  AXI AW valid
aw_ready_i  input  1  AXI AW ready
aw_addr_o  output  AddrWidth  burst address
aw_len_o  output  8  burst beats minus one
aw_size_o  output  3  log2(DataWidth/8), constant
aw_burst_o  output  2  constant INCR (2'b01)
w_valid_o  output  1  AXI W valid
w_ready_i  input  1  AXI W ready
w_data_o  output  DataWidth  AXI W data
w_strb_o  output  DataWidth/8  all ones
w_last_o  output  1  last beat of current burst
b_valid_i  input  1  AXI B valid
b_ready_o  output  1  AXI B ready
b_resp_i  input  2  AXI B response
busy_o  output  1  transfer in progress; feeds counter busy_i
trans_len_o  output  LenWidth  latched req_len_i; feeds counter trans_len_i
done_o  output  1  one-cycle pulse at transfer end
error_o  output  1  sticky: any B response != OKAY in current/last transfer

Behaviour:
- Reset (async assert, sync release): state IDLE; all registered outputs 0; trans_len_o=0; error_o=0.
- States: IDLE, AW, W, B, DONE.
- IDLE:
  - req_ready_o=1.
  - On accept: latch addr and len; set remaining=len; trans_len_o=len; busy_o=1; clear error_o.
  - Next state: AW if len!=0, else DONE.
- AW:
  - aw_valid_o=1 (registered, asserted the cycle after entry).
  - beats = min(remaining, MaxBurstBeats); aw_len_o = beats-1.
  - Address and length held stable until aw_ready_i.
  - On handshake: load beat counter = beats; go to W.
- W:
  - w_valid_o = data_valid_i; data_ready_o = w_ready_i; w_data_o = data_i (combinational pass-through).
  - Data source must hold valid/data until ready, per stream rules.
  - w_last_o=1 when beat counter == 1.
  - Each w_valid_o&&w_ready_i decrements beat counter and remaining.
  - On last-beat handshake: go to B.
  - Outside W: w_valid_o=0, data_ready_o=0.
- B:
  - b_ready_o=1.
  - On b_valid_i: error_o |= (b_resp_i != 2'b00); advance addr by beats*DataWidth/8.
  - Next state: AW if remaining != 0, else DONE.
- DONE: done_o=1 for exactly one cycle; busy_o drops in the same cycle; next state IDLE.
- Concurrency: exactly one outstanding burst; AW never overlaps W or B.
- Address arithmetic: modulo 2^AddrWidth. 4KB-boundary splitting is out of scope; caller guarantees compliance.
- Remaining counter width LenWidth: no overflow, since it only decrements from req_len_i.
- Empty request (req_len_i=0): exactly one done_o pulse two cycles after accept; no AW/W/B traffic.
- req_valid_i while busy: ignored; req_ready_o=0.
- Reset mid-operation: immediate return to IDLE; all valids deasserted. Any partially issued AXI transaction is abandoned; the system resets the interconnect together with this block.

Decomposition:
- Package xdma_axi_write_pkg:
  - state enum write_state_e
  - AXI constants: AxiBurstIncr, AxiRespOkay
  - function clog2-based size computation
  - typedefs addr_t, len_t, data_t, strb_t
- One natural sub-module, xdma_burst_splitter: holds current address/remaining and produces the next aw_addr/aw_len plus the post-burst updates. Keeps the FSM thin and is separately testable.

Test Plan:
- len=4, addr=0x1000, ready always high -> one AW (aw_len=3, addr 0x1000); 4 W beats, w_last on 4th; one B; done_o one pulse; busy_o high from accept to done.
- len=600, MaxBurstBeats=256, DataWidth=512 -> three bursts, aw_len=255,255,87; addrs 0x0, 0x4000, 0x8000; exactly 600 W handshakes; counter trans_complete_o aligned with final beat.
- Random w_ready_i/data_valid_i stalls (0-5 cycles), len=4 -> w_valid_o never asserted without data_valid_i; beat order preserved; w_last only on beat 4.
- Second burst B returns SLVERR, len=300 -> transfer still completes, error_o=1 after that B and held; next accepted request clears error_o.
- len=0 -> req accepted, done_o pulses two cycles later, no aw_valid_o/w_valid_o activity.
- rst_ni asserted mid-W (after beat 2 of 4) -> all valids and busy_o drop immediately; after release, a new len=2 request completes normally.

Source files
------------

// File: rtl/xdma_axi_write_pkg.sv
// rtl/xdma_axi_write_pkg.sv - shared types and AXI constants for the XDMA write engine
package xdma_axi_write_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } write_state_e;

    localparam logic [1:0] AxiBurstIncr = 2'b01;
    localparam logic [1:0] AxiRespOkay  = 2'b00;

    localparam int unsigned DefAddrWidth = 48;
    localparam int unsigned DefDataWidth = 512;
    localparam int unsigned DefLenWidth  = 16;

    typedef logic [DefAddrWidth-1:0]   addr_t;
    typedef logic [DefLenWidth-1:0]    len_t;
    typedef logic [DefDataWidth-1:0]   data_t;
    typedef logic [DefDataWidth/8-1:0] strb_t;

    // AxSIZE encodes bytes per beat as a power of two.
    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/xdma_burst_splitter.sv
// rtl/xdma_burst_splitter.sv - tracks transfer address/remaining beats and sizes each burst
module xdma_burst_splitter
    import xdma_axi_write_pkg::*;
#(
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DataWidth     = 512,
    parameter int unsigned LenWidth      = 16,
    parameter int unsigned MaxBurstBeats = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [AddrWidth-1:0] load_addr_i,
    input  logic [LenWidth-1:0]  load_len_i,
    input  logic                 aw_fire_i,
    input  logic                 beat_fire_i,
    input  logic                 b_fire_i,
    output logic [AddrWidth-1:0] aw_addr_o,
    output logic [7:0]           aw_len_o,
    output logic [8:0]           burst_beats_o,
    output logic                 remaining_zero_o
);

    localparam int unsigned ByteShift = $clog2(DataWidth / 8);

    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [LenWidth-1:0]  remaining_q, remaining_d;
    logic [8:0]           cur_beats_q, cur_beats_d;
    logic [8:0]           beats;

    always_comb begin
        if (remaining_q >= LenWidth'(MaxBurstBeats)) begin
            beats = 9'(MaxBurstBeats);
        end else begin
            beats = 9'(remaining_q);
        end
    end

    assign aw_addr_o        = addr_q;
    assign aw_len_o         = (beats == 9'd0) ? 8'd0 : 8'(beats - 9'd1);
    assign burst_beats_o    = beats;
    assign remaining_zero_o = (remaining_q == '0);

    // Burst size is frozen at AW so the address step survives the per-beat decrements.
    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        cur_beats_d = cur_beats_q;
        if (load_i) begin
            addr_d      = load_addr_i;
            remaining_d = load_len_i;
        end else begin
            if (aw_fire_i) begin
                cur_beats_d = beats;
            end
            if (beat_fire_i) begin
                remaining_d = remaining_q - LenWidth'(1);
            end
            if (b_fire_i) begin
                addr_d = addr_q + (AddrWidth'(cur_beats_q) << ByteShift);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q      <= '0;
            remaining_q <= '0;
            cur_beats_q <= '0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            cur_beats_q <= cur_beats_d;
        end
    end

endmodule

// File: rtl/xdma_axi_write_fsm.sv
// rtl/xdma_axi_write_fsm.sv - splits a write transfer into AXI4 INCR bursts, one outstanding at a time
module xdma_axi_write_fsm
    import xdma_axi_write_pkg::*;
#(
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DataWidth     = 512,
    parameter int unsigned LenWidth      = 16,
    parameter int unsigned MaxBurstBeats = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [LenWidth-1:0]    req_len_i,
    input  logic                   data_valid_i,
    output logic                   data_ready_o,
    input  logic [DataWidth-1:0]   data_i,
    output logic                   aw_valid_o,
    input  logic                   aw_ready_i,
    output logic [AddrWidth-1:0]   aw_addr_o,
    output logic [7:0]             aw_len_o,
    output logic [2:0]             aw_size_o,
    output logic [1:0]             aw_burst_o,
    output logic                   w_valid_o,
    input  logic                   w_ready_i,
    output logic [DataWidth-1:0]   w_data_o,
    output logic [DataWidth/8-1:0] w_strb_o,
    output logic                   w_last_o,
    input  logic                   b_valid_i,
    output logic                   b_ready_o,
    input  logic [1:0]             b_resp_i,
    output logic                   busy_o,
    output logic [LenWidth-1:0]    trans_len_o,
    output logic                   done_o,
    output logic                   error_o
);

    write_state_e        state_q, state_d;
    logic                aw_valid_q, aw_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [LenWidth-1:0] trans_len_q, trans_len_d;
    logic [8:0]          beat_cnt_q, beat_cnt_d;

    logic       req_fire, aw_fire, w_fire, b_fire;
    logic       in_w;
    logic [8:0] burst_beats;
    logic       remaining_zero;

    assign in_w     = (state_q == ST_W);
    assign req_fire = (state_q == ST_IDLE) && req_valid_i;
    assign aw_fire  = aw_valid_q && aw_ready_i;
    assign w_fire   = w_valid_o && w_ready_i;
    assign b_fire   = (state_q == ST_B) && b_valid_i;

    xdma_burst_splitter #(
        .AddrWidth    (AddrWidth),
        .DataWidth    (DataWidth),
        .LenWidth     (LenWidth),
        .MaxBurstBeats(MaxBurstBeats)
    ) u_splitter (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .load_i          (req_fire),
        .load_addr_i     (req_addr_i),
        .load_len_i      (req_len_i),
        .aw_fire_i       (aw_fire),
        .beat_fire_i     (w_fire),
        .b_fire_i        (b_fire),
        .aw_addr_o       (aw_addr_o),
        .aw_len_o        (aw_len_o),
        .burst_beats_o   (burst_beats),
        .remaining_zero_o(remaining_zero)
    );

    assign req_ready_o  = (state_q == ST_IDLE);
    assign aw_valid_o   = aw_valid_q;
    assign aw_size_o    = axi_size(DataWidth);
    assign aw_burst_o   = AxiBurstIncr;
    assign w_valid_o    = in_w && data_valid_i;
    assign data_ready_o = in_w && w_ready_i;
    assign w_data_o     = data_i;
    assign w_strb_o     = '1;
    assign w_last_o     = in_w && (beat_cnt_q == 9'd1);
    assign b_ready_o    = (state_q == ST_B);
    assign busy_o       = busy_q;
    assign trans_len_o  = trans_len_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

    always_comb begin
        state_d     = state_q;
        aw_valid_d  = aw_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        trans_len_d = trans_len_q;
        beat_cnt_d  = beat_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    trans_len_d = req_len_i;
                    busy_d      = 1'b1;
                    error_d     = 1'b0;
                    if (req_len_i != '0) begin
                        state_d    = ST_AW;
                        aw_valid_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_AW: begin
                if (aw_fire) begin
                    aw_valid_d = 1'b0;
                    beat_cnt_d = burst_beats;
                    state_d    = ST_W;
                end
            end
            ST_W: begin
                if (w_fire) begin
                    beat_cnt_d = beat_cnt_q - 9'd1;
                    if (beat_cnt_q == 9'd1) begin
                        state_d = ST_B;
                    end
                end
            end
            ST_B: begin
                if (b_valid_i) begin
                    error_d = error_q | (b_resp_i != AxiRespOkay);
                    if (remaining_zero) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_AW;
                        aw_valid_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // done and busy are registered, so both flip together on the way back to idle
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                aw_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            aw_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            trans_len_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            aw_valid_q  <= aw_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            trans_len_q <= trans_len_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_xdma_axi_write_fsm.sv
// tb/tb_xdma_axi_write_fsm.sv - directed transfers checked against a transaction-level burst model
module tb_xdma_axi_write_fsm;

    localparam int AW = 48;
    localparam int DW = 512;
    localparam int LW = 16;
    localparam int MAXB = 256;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic [AW-1:0]   req_addr_i = '0;
    logic [LW-1:0]   req_len_i = '0;
    logic            data_valid_i = 1'b0;
    logic            data_ready_o;
    logic [DW-1:0]   data_i;
    logic            aw_valid_o;
    logic            aw_ready_i = 1'b1;
    logic [AW-1:0]   aw_addr_o;
    logic [7:0]      aw_len_o;
    logic [2:0]      aw_size_o;
    logic [1:0]      aw_burst_o;
    logic            w_valid_o;
    logic            w_ready_i = 1'b1;
    logic [DW-1:0]   w_data_o;
    logic [DW/8-1:0] w_strb_o;
    logic            w_last_o;
    logic            b_valid_i = 1'b0;
    logic            b_ready_o;
    logic [1:0]      b_resp_i = 2'b00;
    logic            busy_o;
    logic [LW-1:0]   trans_len_o;
    logic            done_o;
    logic            error_o;

    always #5 clk = ~clk;

    xdma_axi_write_fsm #(
        .AddrWidth(AW), .DataWidth(DW), .LenWidth(LW), .MaxBurstBeats(MAXB)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
        .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
        .w_strb_o(w_strb_o), .w_last_o(w_last_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
        .busy_o(busy_o), .trans_len_o(trans_len_o), .done_o(done_o), .error_o(error_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int seq);
        logic [31:0] w;
        w = 32'(seq) ^ 32'h5A00_0000;
        return {16{w}};
    endfunction

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } burst_t;

    burst_t        exp_q[$];
    burst_t        aw_log[$];
    int            cyc = 0;
    bit            outstanding = 0;
    int            beats_in_burst = 0;
    int            beat_idx = 0;
    int            exp_seq = 0;
    bit            exp_err = 0;
    bit            busy_flag = 0;
    logic [LW-1:0] exp_len = '0;
    int            done_cnt = 0;
    int            done_count = 0;
    int            w_fires = 0;
    int            aw_cycles = 0;
    int            w_cycles = 0;
    int            accept_cyc = 0;
    int            done_cyc = 0;
    bit            src_fire = 0;
    bit            last_fire = 0;
    bit            b_fire = 0;
    bit            acc_fire = 0;
    bit            stall_en = 0;
    int            slverr_idx = -1;
    int            src_seq = 0;
    int            b_idx = 0;

    // Transaction model: expected bursts come from plain arithmetic on the request.
    always @(negedge clk) begin
        bit exp_done;
        cyc++;
        src_fire  = 0;
        last_fire = 0;
        b_fire    = 0;
        acc_fire  = 0;
        if (!rst_ni) begin
            exp_q.delete();
            outstanding = 0;
            busy_flag   = 0;
            exp_err     = 0;
            done_cnt    = 0;
        end else begin
            exp_done = (done_cnt == 1);
            chk_eq("done_o", done_o, exp_done);
            chk_eq("busy_o", busy_o, busy_flag && !exp_done);
            chk_eq("req_ready_o", req_ready_o, !(busy_flag && !exp_done));
            chk_eq("error_o", error_o, exp_err);
            if (busy_flag) chk_eq("trans_len_o", trans_len_o, exp_len);
            chk_eq("src_vs_w_handshake", data_valid_i && data_ready_o, w_valid_o && w_ready_i);
            if (aw_valid_o) begin
                aw_cycles++;
                chk_eq("aw_during_burst", outstanding, 0);
            end
            if (w_valid_o) begin
                w_cycles++;
                chk_eq("w_valid_without_src", data_valid_i, 1);
                chk_eq("w_overlaps_aw", aw_valid_o, 0);
            end
            if (done_cnt > 0) done_cnt--;
            if (exp_done) begin
                done_count++;
                done_cyc  = cyc;
                busy_flag = 0;
                chk_eq("done_leftover_bursts", exp_q.size() + int'(outstanding), 0);
            end
            if (req_valid_i && req_ready_o) begin
                int unsigned rem;
                logic [AW-1:0] a;
                acc_fire   = 1;
                accept_cyc = cyc;
                exp_len    = req_len_i;
                exp_err    = 0;
                busy_flag  = 1;
                rem        = req_len_i;
                a          = req_addr_i;
                while (rem > 0) begin
                    int unsigned nb;
                    burst_t bt;
                    nb = (rem > MAXB) ? MAXB : rem;
                    bt.addr = a;
                    bt.len  = 8'(nb - 1);
                    exp_q.push_back(bt);
                    a   = a + AW'(nb * (DW / 8));
                    rem = rem - nb;
                end
                if (req_len_i == 0) done_cnt = 2;
            end
            if (aw_valid_o && aw_ready_i) begin
                burst_t got;
                got.addr = aw_addr_o;
                got.len  = aw_len_o;
                aw_log.push_back(got);
                if (exp_q.size() == 0) begin
                    chk_eq("aw_unexpected", 1, 0);
                end else begin
                    burst_t e;
                    e = exp_q.pop_front();
                    chk_eq("aw_addr", aw_addr_o, e.addr);
                    chk_eq("aw_len", aw_len_o, e.len);
                    beats_in_burst = int'(e.len) + 1;
                end
                outstanding = 1;
                beat_idx    = 0;
            end
            if (w_valid_o && w_ready_i) begin
                chk_eq("w_outside_burst", outstanding, 1);
                chk_eq("w_last", w_last_o, beat_idx == beats_in_burst - 1);
                chk_eq("w_data", w_data_o[63:0], mk_data(exp_seq) >> 0);
                chk_eq("w_data_full", w_data_o == mk_data(exp_seq), 1);
                exp_seq++;
                beat_idx++;
                w_fires++;
                if (w_last_o) last_fire = 1;
            end
            if (data_valid_i && data_ready_o) src_fire = 1;
            if (b_valid_i && b_ready_o) begin
                chk_eq("b_before_last_beat", beat_idx, beats_in_burst);
                outstanding = 0;
                if (b_resp_i != 2'b00) exp_err = 1;
                b_fire = 1;
                if (exp_q.size() == 0) done_cnt = 2;
            end
        end
    end

    initial data_i = mk_data(0);

    always @(posedge clk) begin
        #1;
        if (src_fire) begin
            src_seq++;
            data_i       = mk_data(src_seq);
            data_valid_i = 1'b0;
        end
        if (!data_valid_i) data_valid_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        w_ready_i  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        aw_ready_i = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    always @(posedge clk) begin
        #1;
        if (acc_fire) b_idx = 0;
        if (!rst_ni || b_fire) b_valid_i = 1'b0;
        if (last_fire && rst_ni) begin
            b_valid_i = 1'b1;
            b_resp_i  = (b_idx == slverr_idx) ? 2'b10 : 2'b00;
            b_idx++;
        end
    end

    task automatic issue_req(input logic [AW-1:0] a, input logic [LW-1:0] l);
        int t;
        aw_log.delete();
        @(posedge clk);
        #1;
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_len_i   = l;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready_o && t < 200);
        chk_eq("req_accept_timeout", req_ready_o, 1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic run_req(input logic [AW-1:0] a, input logic [LW-1:0] l);
        int n0, t;
        n0 = done_count;
        issue_req(a, l);
        t = 0;
        while (done_count == n0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk_eq("done_timeout", done_count, n0 + 1);
        @(negedge clk);
    endtask

    initial begin
        int wf0, aw0, wc0, t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_busy", busy_o, 0);
        chk_eq("rst_done", done_o, 0);
        chk_eq("rst_aw_valid", aw_valid_o, 0);
        chk_eq("rst_w_valid", w_valid_o, 0);
        chk_eq("rst_b_ready", b_ready_o, 0);
        chk_eq("rst_trans_len", trans_len_o, 0);
        chk_eq("rst_error", error_o, 0);
        chk_eq("aw_size", aw_size_o, 3'd6);
        chk_eq("aw_burst", aw_burst_o, 2'b01);
        chk_eq("w_strb_all_ones", &w_strb_o, 1);
        #2 rst_ni = 1'b1;
        @(negedge clk);
        chk_eq("idle_req_ready", req_ready_o, 1);

        wf0 = w_fires;
        run_req(48'h1000, 16'd4);
        chk_eq("t1_aw_count", aw_log.size(), 1);
        if (aw_log.size() == 1) begin
            chk_eq("t1_aw_addr", aw_log[0].addr, 48'h1000);
            chk_eq("t1_aw_len", aw_log[0].len, 8'd3);
        end
        chk_eq("t1_beats", w_fires - wf0, 4);

        wf0 = w_fires;
        run_req(48'h0, 16'd600);
        chk_eq("t2_aw_count", aw_log.size(), 3);
        if (aw_log.size() == 3) begin
            chk_eq("t2_len0", aw_log[0].len, 8'd255);
            chk_eq("t2_len1", aw_log[1].len, 8'd255);
            chk_eq("t2_len2", aw_log[2].len, 8'd87);
            chk_eq("t2_addr0", aw_log[0].addr, 48'h0);
            chk_eq("t2_addr1", aw_log[1].addr, 48'h4000);
            chk_eq("t2_addr2", aw_log[2].addr, 48'h8000);
        end
        chk_eq("t2_beats", w_fires - wf0, 600);
        chk_eq("t2_trans_len", trans_len_o, 16'd600);

        stall_en = 1;
        wf0 = w_fires;
        run_req(48'h2000, 16'd4);
        chk_eq("t3_beats", w_fires - wf0, 4);
        chk_eq("t3_aw_count", aw_log.size(), 1);
        stall_en = 0;

        slverr_idx = 1;
        run_req(48'h10000, 16'd300);
        chk_eq("t4_error_held", error_o, 1);
        if (aw_log.size() == 2) chk_eq("t4_len1", aw_log[1].len, 8'd43);
        else chk_eq("t4_aw_count", aw_log.size(), 2);
        slverr_idx = -1;
        run_req(48'h40, 16'd1);
        chk_eq("t4_error_cleared", error_o, 0);

        aw0 = aw_cycles;
        wc0 = w_cycles;
        run_req(48'h3000, 16'd0);
        chk_eq("t5_done_latency", done_cyc - accept_cyc, 2);
        chk_eq("t5_no_aw", aw_cycles - aw0, 0);
        chk_eq("t5_no_w", w_cycles - wc0, 0);

        wf0 = w_fires;
        issue_req(48'h5000, 16'd4);
        t = 0;
        while (w_fires < wf0 + 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk_eq("t6_reach_beat2", w_fires - wf0, 2);
        @(posedge clk);
        #1 rst_ni = 1'b0;
        #1;
        chk_eq("t6_rst_w_valid", w_valid_o, 0);
        chk_eq("t6_rst_aw_valid", aw_valid_o, 0);
        chk_eq("t6_rst_busy", busy_o, 0);
        chk_eq("t6_rst_b_ready", b_ready_o, 0);
        chk_eq("t6_rst_data_ready", data_ready_o, 0);
        repeat (2) @(negedge clk);
        #2 rst_ni = 1'b1;
        wf0 = w_fires;
        run_req(48'h6000, 16'd2);
        chk_eq("t6_beats", w_fires - wf0, 2);
        if (aw_log.size() == 1) begin
            chk_eq("t6_aw_addr", aw_log[0].addr, 48'h6000);
            chk_eq("t6_aw_len", aw_log[0].len, 8'd1);
        end else begin
            chk_eq("t6_aw_count", aw_log.size(), 1);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
